draw_figure_layer: RTL and testbench

- Parametrised successor to the fixed 64x64 single-board figure renderer.
- Streams VGA timing through a pipeline and overlays 2-bit-per-pixel chess figure bitmaps onto an 8x8 board at a configurable origin and square size.
- Fetches bitmap rows from the external figure ROM with a configurable read latency.
- Adds a frame-latched, blinking cursor frame on one selected square.
- Sits between the board-drawing stage and the mouse/output stage.

---
 rtl/draw_figure_layer_if.sv | 14 +
 rtl/draw_figure_layer.sv | 193 +++++++++++++++++++
 tb/tb_draw_figure_layer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_figure_layer_if.sv
// VGA timing bundle passed between the drawing stages.
// The master modport drives the fields and the slave modport reads them.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_figure_layer.sv
// Chess figure overlay: draws 2-bpp figure bitmaps onto an 8x8 board at a
// configurable origin and square size, plus a blinking cursor frame on one
// square. Bitmap rows come from an external ROM with FETCH_LAT clocks of read
// latency; the timing stream is delayed to match, so vga_in to vga_out takes
// FETCH_LAT+2 clocks.
// Optional macro BOARD_FLIP_EN adds a board_flip input that mirrors the square
// index (63 - {row,col}) for the black-side view.
module draw_figure_layer #(
  parameter int          BOARD_X      = 0,
  parameter int          BOARD_Y      = 0,
  parameter int          SQ_LOG2      = 6,
  parameter int          BMP_LOG2     = 5,
  parameter int          FETCH_LAT    = 1,
  parameter logic [11:0] COL_DARK     = 12'h666,
  parameter logic [11:0] COL_LIGHT    = 12'hfff,
  parameter logic [11:0] COL_OUTLINE  = 12'h000,
  parameter logic [11:0] COL_CURSOR   = 12'hf00,
  parameter int          CURSOR_W     = 2,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2*(2**BMP_LOG2)-1:0]      figure_pixels,
  output logic [5:0]                      figure_xy,
  output logic [BMP_LOG2-1:0]             figure_line,
  input  logic [5:0]                      cursor_xy,
  input  logic                            cursor_valid,
`ifdef BOARD_FLIP_EN
  input  logic                            board_flip,
`endif
  vga_if.slave                            vga_in,
  vga_if.master                           vga_out
);

  localparam int SQ    = 2**SQ_LOG2;
  localparam int BMP   = 2**BMP_LOG2;
  localparam int SHIFT = SQ_LOG2 - BMP_LOG2;
  localparam int DLY   = 1 + FETCH_LAT;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [11:0]        X_LO = 12'(BOARD_X);
  localparam logic [11:0]        X_HI = 12'(BOARD_X + 8*SQ);
  localparam logic [11:0]        Y_LO = 12'(BOARD_Y);
  localparam logic [11:0]        Y_HI = 12'(BOARD_Y + 8*SQ);
  localparam logic [SQ_LOG2-1:0] CW_LO = SQ_LOG2'(CURSOR_W);
  localparam logic [SQ_LOG2-1:0] CW_HI = SQ_LOG2'(SQ - CURSOR_W);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [10:0]         vcount;
    logic                vsync;
    logic                vblnk;
    logic [10:0]         hcount;
    logic                hsync;
    logic                hblnk;
    logic [11:0]         rgb;
    logic                in_board;
    logic [BMP_LOG2-1:0] px;
    logic [SQ_LOG2-1:0]  xo;
    logic [SQ_LOG2-1:0]  yo;
    logic [5:0]          sq;
  } pipe_t;

  pipe_t pipe [DLY];

  // Only the low SQ_LOG2+3 bits of the board-relative offsets are ever used.
  logic [SQ_LOG2+2:0]  dx, dy;
  logic                in_board_c;
  logic                frame_start;
  logic [5:0]          idx_c, sq_c;
  logic [BMP_LOG2-1:0] px_c, line_c;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             cur_valid;
  logic             cur_vis;
  logic [5:0]       cur_xy;

  assign dx = (SQ_LOG2+3)'(vga_in.hcount - 11'(BOARD_X));
  assign dy = (SQ_LOG2+3)'(vga_in.vcount - 11'(BOARD_Y));
  assign in_board_c = ({1'b0, vga_in.hcount} >= X_LO) && ({1'b0, vga_in.hcount} < X_HI) &&
                      ({1'b0, vga_in.vcount} >= Y_LO) && ({1'b0, vga_in.vcount} < Y_HI);
  assign frame_start = (vga_in.vcount == 11'd0) && (vga_in.hcount == 11'd0);
  assign idx_c  = {dy[SQ_LOG2+2:SQ_LOG2], dx[SQ_LOG2+2:SQ_LOG2]};
  assign px_c   = BMP_LOG2'(dx[SQ_LOG2-1:0] >> SHIFT);
  assign line_c = BMP_LOG2'(dy[SQ_LOG2-1:0] >> SHIFT);

`ifdef BOARD_FLIP_EN
  logic flip_q;
  logic flip_eff;
  // The frame-start pixel already uses the flip value being latched with it.
  assign flip_eff = frame_start ? board_flip : flip_q;
  assign sq_c     = flip_eff ? (6'd63 - idx_c) : idx_c;
`else
  assign sq_c = idx_c;
`endif

  // Stage A: board decode, ROM address, and the delay line that tracks ROM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) pipe[i] <= '0;
      figure_xy   <= '0;
      figure_line <= '0;
    end else begin
      pipe[0] <= '{vcount: vga_in.vcount, vsync: vga_in.vsync, vblnk: vga_in.vblnk,
                   hcount: vga_in.hcount, hsync: vga_in.hsync, hblnk: vga_in.hblnk,
                   rgb: vga_in.rgb, in_board: in_board_c, px: px_c,
                   xo: dx[SQ_LOG2-1:0], yo: dy[SQ_LOG2-1:0], sq: sq_c};
      for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
      if (in_board_c) begin
        figure_xy   <= sq_c;
        figure_line <= line_c;
      end
    end
  end

  // Frame-start latch of cursor state and blink counter; cur_vis captures the
  // phase in force before this frame's update so each blink half lasts exactly
  // BLINK_FRAMES frames counted from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      cur_valid   <= 1'b0;
      cur_vis     <= 1'b1;
      cur_xy      <= '0;
`ifdef BOARD_FLIP_EN
      flip_q      <= 1'b0;
`endif
    end else if (frame_start) begin
      cur_valid <= cursor_valid;
      cur_xy    <= cursor_xy;
      cur_vis   <= blink_phase;
`ifdef BOARD_FLIP_EN
      flip_q    <= board_flip;
`endif
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  pipe_t            s;
  logic [2*BMP-1:0] pix_sh;
  logic [1:0]       code;
  logic             on_edge;
  logic [11:0]      rgb_c;

  assign s       = pipe[DLY-1];
  assign pix_sh  = figure_pixels << {s.px, 1'b0};
  assign code    = pix_sh[2*BMP-1 -: 2];
  assign on_edge = (s.xo < CW_LO) || (s.xo >= CW_HI) || (s.yo < CW_LO) || (s.yo >= CW_HI);

  // Stage B colour select: figure decode, then the cursor frame on top; both
  // are restricted to visible board pixels.
  always_comb begin
    rgb_c = s.rgb;
    if (s.in_board && !s.hblnk && !s.vblnk) begin
      case (code)
        2'b01:   rgb_c = COL_DARK;
        2'b10:   rgb_c = COL_LIGHT;
        2'b11:   rgb_c = COL_OUTLINE;
        default: rgb_c = s.rgb;
      endcase
      if (cur_valid && cur_vis && (s.sq == cur_xy) && on_edge) rgb_c = COL_CURSOR;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= s.vcount;
      vga_out.vsync  <= s.vsync;
      vga_out.vblnk  <= s.vblnk;
      vga_out.hcount <= s.hcount;
      vga_out.hsync  <= s.hsync;
      vga_out.hblnk  <= s.hblnk;
      vga_out.rgb    <= rgb_c;
    end
  end

endmodule

// File: tb/tb_draw_figure_layer.sv
// Bench for draw_figure_layer: two instances (FETCH_LAT 1 and 3, BLINK_FRAMES 2)
// share one input stream; every output cycle is compared with a behavioural
// model of the board, figure codes, cursor latch and blink sequence.
module tb_draw_figure_layer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] cursor_xy;
  logic       cursor_valid;
`ifdef BOARD_FLIP_EN
  logic       board_flip;
`endif

  vga_if vin();
  vga_if vo1();
  vga_if vo3();

  logic [63:0] fp1, fp3;
  logic [5:0]  xy1, xy3;
  logic [4:0]  ln1, ln3;
  logic [63:0] r3 [3];

  assign fp1 = {4{16'hAAAA}};

  // ROM for the FETCH_LAT=3 instance: code 01 only at px 0 of square 9.
  always @(posedge clk) begin
    r3[0] <= (xy3 == 6'd9) ? {2'b01, 62'd0} : 64'd0;
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign fp3 = r3[2];

  draw_figure_layer #(.FETCH_LAT(1), .BLINK_FRAMES(2)) dut1 (
    .clk(clk), .rst(rst), .figure_pixels(fp1), .figure_xy(xy1), .figure_line(ln1),
    .cursor_xy(cursor_xy), .cursor_valid(cursor_valid),
`ifdef BOARD_FLIP_EN
    .board_flip(board_flip),
`endif
    .vga_in(vin), .vga_out(vo1));

  draw_figure_layer #(.FETCH_LAT(3), .BLINK_FRAMES(2)) dut3 (
    .clk(clk), .rst(rst), .figure_pixels(fp3), .figure_xy(xy3), .figure_line(ln3),
    .cursor_xy(cursor_xy), .cursor_valid(cursor_valid),
`ifdef BOARD_FLIP_EN
    .board_flip(board_flip),
`endif
    .vga_in(vin), .vga_out(vo3));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // model state
  int m_cnt, m_xy, m_fxy, m_fln;
  bit m_ph, m_valid, m_vis, m_flip;
  int n = 0;
  int last_rst = -100;
  logic [37:0] e1 [4096];
  logic [37:0] e3 [4096];

  function automatic logic [37:0] pk(logic [10:0] v, logic vs, logic vb, logic [10:0] h,
                                     logic hs, logic hb, logic [11:0] rgb);
    return {v, vs, vb, h, hs, hb, rgb};
  endfunction

  function automatic logic [11:0] model_rgb(bit is3, int h, int v, logic [11:0] rgb, bit hb, bit vb);
    int sq, xo, yo, px;
    logic [1:0] code;
    logic [11:0] r;
    r = rgb;
    if (h < 512 && v < 512 && !hb && !vb) begin
      sq = (v / 64) * 8 + (h / 64);
      if (m_flip) sq = 63 - sq;
      xo = h % 64; yo = v % 64; px = xo / 2;
      if (is3) code = (sq == 9 && px == 0) ? 2'b01 : 2'b00;
      else     code = 2'b10;
      case (code)
        2'b01:   r = 12'h666;
        2'b10:   r = 12'hfff;
        2'b11:   r = 12'h000;
        default: r = rgb;
      endcase
      if (m_valid && m_vis && sq == m_xy && (xo < 2 || xo >= 62 || yo < 2 || yo >= 62))
        r = 12'hf00;
    end
    return r;
  endfunction

  task automatic cyc(input int h, input int v, input bit hb = 0, input bit vb = 0);
    logic [10:0] hh, vv;
    logic [11:0] rgb;
    int k;
    hh = 11'(h); vv = 11'(v); rgb = 12'h0f0;
    vin.hcount = hh; vin.vcount = vv; vin.hsync = hh[3]; vin.vsync = vv[1];
    vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgb;
    if (rst) begin
      m_cnt = 0; m_ph = 1; m_valid = 0; m_vis = 1; m_xy = 0; m_flip = 0;
      m_fxy = 0; m_fln = 0; last_rst = n;
    end else begin
      if (h == 0 && v == 0) begin
        m_vis = m_ph; m_valid = cursor_valid; m_xy = cursor_xy;
`ifdef BOARD_FLIP_EN
        m_flip = board_flip;
`endif
        if (m_cnt == 1) begin m_cnt = 0; m_ph = ~m_ph; end
        else m_cnt++;
      end
      if (h < 512 && v < 512) begin
        m_fxy = (v / 64) * 8 + (h / 64);
        if (m_flip) m_fxy = 63 - m_fxy;
        m_fln = (v % 64) / 2;
      end
    end
    e1[n % 4096] = pk(vv, vv[1], vb, hh, hh[3], hb, model_rgb(0, h, v, rgb, hb, vb));
    e3[n % 4096] = pk(vv, vv[1], vb, hh, hh[3], hb, model_rgb(1, h, v, rgb, hb, vb));
    @(posedge clk);
    #1;
    k = n - 2;
    chk("out_l1", 64'(pk(vo1.vcount, vo1.vsync, vo1.vblnk, vo1.hcount, vo1.hsync, vo1.hblnk, vo1.rgb)),
        (n - last_rst < 3) ? 64'd0 : 64'(e1[k % 4096]));
    k = n - 4;
    chk("out_l3", 64'(pk(vo3.vcount, vo3.vsync, vo3.vblnk, vo3.hcount, vo3.hsync, vo3.hblnk, vo3.rgb)),
        (n - last_rst < 5) ? 64'd0 : 64'(e3[k % 4096]));
    chk("rom_addr1", {53'd0, xy1, ln1}, 64'(m_fxy * 32 + m_fln));
    chk("rom_addr3", {53'd0, xy3, ln3}, 64'(m_fxy * 32 + m_fln));
    n++;
  endtask

  task automatic new_frame();
    repeat (5) cyc(800, 600, 1, 1);
    cyc(0, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(800, 600, 1, 1);
    rst = 1'b0;
  endtask

  task automatic cursor_probe(input int bx, input int by);
    for (int i = 0; i < 3; i++) cyc(bx + i, by + 1);
    for (int i = 60; i < 66; i++) cyc(bx + i, by + 30);
    for (int j = 0; j < 3; j++) cyc(bx + 30, by + j);
    for (int j = 60; j < 66; j++) cyc(bx + 30, by + j);
  endtask

  initial begin
    rst = 1'b1; cursor_valid = 1'b0; cursor_xy = 6'd0;
`ifdef BOARD_FLIP_EN
    board_flip = 1'b0;
`endif
    repeat (3) cyc(800, 600, 1, 1);
    rst = 1'b0;

    // all-light figures, square 9 dark pixel, board edges, blanking
    new_frame();
    for (int h = 0; h < 80; h++) cyc(h, 64);
    for (int h = 60; h < 71; h++) cyc(h, 127);
    for (int h = 60; h < 71; h++) cyc(h, 128);
    for (int h = 508; h < 516; h++) cyc(h, 5);
    for (int v = 508; v < 516; v++) cyc(100, v);
    for (int h = 62; h < 67; h++) cyc(h, 64, 1, 0);
    for (int h = 62; h < 67; h++) cyc(h, 70, 0, 1);

    // blinking cursor on square 0, six frames from reset
    pulse_rst();
    chk("blink_after_rst", 64'(dut1.blink_phase), 64'd1);
    cursor_valid = 1'b1; cursor_xy = 6'd0;
    for (int f = 0; f < 6; f++) begin
      new_frame();
      cursor_probe(0, 0);
    end

    // mid-frame cursor move takes effect only at the next frame
    pulse_rst();
    cursor_xy = 6'd0;
    new_frame();
    cursor_probe(0, 0);
    cyc(100, 200);
    cursor_xy = 6'd63;
    cursor_probe(0, 0);
    cursor_probe(448, 448);
    new_frame();
    cursor_probe(0, 0);
    cursor_probe(448, 448);

    // one-clock reset in the middle of a line
    new_frame();
    for (int h = 0; h < 20; h++) cyc(h, 64);
    chk("blink_before_rst", 64'(dut1.blink_phase), 64'd0);
    rst = 1'b1;
    cyc(20, 64);
    rst = 1'b0;
    chk("blink_mid_rst", 64'(dut1.blink_phase), 64'd1);
    chk("xy_mid_rst", 64'(xy1), 64'd0);
    for (int h = 21; h < 40; h++) cyc(h, 64);

`ifdef BOARD_FLIP_EN
    // flipped view: top-left screen square is index 63
    board_flip = 1'b1; cursor_valid = 1'b1; cursor_xy = 6'd63;
    new_frame();
    chk("flip_xy00", 64'(xy1), 64'd63);
    cursor_probe(0, 0);
    for (int h = 382; h < 388; h++) cyc(h, 384);
    for (int h = 62; h < 67; h++) cyc(h, 64);
    board_flip = 1'b0;
`endif

    repeat (6) cyc(800, 600, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
